truth_table_sweeper: RTL and testbench

- Sequential stimulus/capture stage that sits directly upstream of a combinational N-input Boolean block and consumes its output.
- Steps an input vector through all 2**N_IN combinations in ascending order and holds each vector for DWELL cycles.
- Samples the block's output for each vector and builds the captured truth table.
- Compares the captured table against an expected table and reports mismatch count and pass/fail, replacing hand-written exhaustive sweeps.

---
 rtl/truth_table_sweeper_pkg.sv | 16 +
 rtl/truth_table_sweeper.sv | 109 ++++++++++
 tb/tb_truth_table_sweeper.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/truth_table_sweeper_pkg.sv
// rtl/truth_table_sweeper_pkg.sv - shared types and sizing helpers for the truth-table sweeper
package truth_table_sweeper_pkg;

    // Sweep controller states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Number of input combinations for an n_in-input Boolean block
    function automatic int n_vec(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - exhaustive stimulus/capture sweep of an N-input Boolean block
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int N_IN  = 3,
    parameter int DWELL = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [n_vec(N_IN)-1:0]    exp_table,
    input  logic                      y_in,
    output logic [N_IN-1:0]           vec_out,
    output logic                      busy,
    output logic                      done,
    output logic [n_vec(N_IN)-1:0]    table_out,
    output logic [N_IN:0]             err_count,
    output logic                      pass
);

    localparam int N_VEC = n_vec(N_IN);
    // Dwell counter never exceeds DWELL-1; keep it at least one bit wide
    localparam int DW    = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [DW-1:0]   DWELL_LAST = DW'(DWELL - 1);
    localparam logic [N_IN-1:0] VEC_LAST   = N_IN'(N_VEC - 1);

    state_t                r_state;
    logic [N_VEC-1:0]      r_exp;
    logic [DW-1:0]         r_dwell;
    logic [N_IN-1:0]       r_vec;
    logic                  r_busy;
    logic                  r_done;
    logic [N_VEC-1:0]      r_table;
    logic [N_IN:0]         r_err;
    logic                  r_pass;

    logic                  w_mis;
    logic [N_IN:0]         w_err_next;

    // Compare of the current sample against the latched expectation, folded into the running count
    always_comb begin
        w_mis      = (y_in != r_exp[r_vec]);
        w_err_next = r_err + {{N_IN{1'b0}}, w_mis};
    end

    // Sweep controller: latch on start, dwell on each vector, sample at the end of the dwell
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_exp   <= '0;
            r_dwell <= '0;
            r_vec   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_table <= '0;
            r_err   <= '0;
            r_pass  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_exp   <= exp_table;
                        r_table <= '0;
                        r_err   <= '0;
                        r_pass  <= 1'b0;
                        r_vec   <= '0;
                        r_dwell <= '0;
                        r_busy  <= 1'b1;
                        r_state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (r_dwell == DWELL_LAST) begin
                        r_table[r_vec] <= y_in;
                        r_err          <= w_err_next;
                        r_dwell        <= '0;
                        if (r_vec != VEC_LAST) begin
                            r_vec <= r_vec + 1'b1;
                        end else begin
                            // Final vector: pass must include this last compare
                            r_pass  <= (w_err_next == '0);
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end
                    end else begin
                        r_dwell <= r_dwell + 1'b1;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign vec_out   = r_vec;
    assign busy      = r_busy;
    assign done      = r_done;
    assign table_out = r_table;
    assign err_count = r_err;
    assign pass      = r_pass;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - self-checking bench for truth_table_sweeper
module tb_truth_table_sweeper;

    localparam int N_IN = 3;
    localparam int NV   = 8;

    logic            clk;
    logic            rst;

    // DWELL=2 instance
    logic            start;
    logic [NV-1:0]   exp_table;
    logic            y_in;
    logic [N_IN-1:0] vec_out;
    logic            busy;
    logic            done;
    logic [NV-1:0]   table_out;
    logic [N_IN:0]   err_count;
    logic            pass;
    logic [NV-1:0]   func;

    // DWELL=1 instance
    logic            start1;
    logic [NV-1:0]   exp_table1;
    logic            y_in1;
    logic [N_IN-1:0] vec_out1;
    logic            busy1;
    logic            done1;
    logic [NV-1:0]   table_out1;
    logic [N_IN:0]   err_count1;
    logic            pass1;
    logic [NV-1:0]   func1;

    int n_cmp;
    int n_bad;

    // The Boolean block under sweep: an arbitrary truth table looked up by the driven vector
    assign y_in  = func[vec_out];
    assign y_in1 = func1[vec_out1];

    truth_table_sweeper #(.N_IN(N_IN), .DWELL(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .exp_table (exp_table),
        .y_in      (y_in),
        .vec_out   (vec_out),
        .busy      (busy),
        .done      (done),
        .table_out (table_out),
        .err_count (err_count),
        .pass      (pass)
    );

    truth_table_sweeper #(.N_IN(N_IN), .DWELL(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .start     (start1),
        .exp_table (exp_table1),
        .y_in      (y_in1),
        .vec_out   (vec_out1),
        .busy      (busy1),
        .done      (done1),
        .table_out (table_out1),
        .err_count (err_count1),
        .pass      (pass1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One full DWELL=2 sweep; expected results come from set arithmetic on the tables
    task automatic sweep(input logic [NV-1:0] f, input logic [NV-1:0] e, input bit extra, input string tag);
        int errs;
        errs = $countones(f ^ e);
        @(negedge clk);
        func      = f;
        exp_table = e;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start     = 1'b0;
        exp_table = ~e;
        for (int k = 0; k < NV * 2; k++) begin
            chk($sformatf("%s_busy_%0d", tag, k), 32'(busy), 32'd1);
            chk($sformatf("%s_vec_%0d", tag, k), 32'(vec_out), 32'(k / 2));
            chk($sformatf("%s_done_lo_%0d", tag, k), 32'(done), 32'd0);
            start = extra && (k == 3 || k == 9);
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, "_done"},  32'(done), 32'd1);
        chk({tag, "_busy0"}, 32'(busy), 32'd0);
        chk({tag, "_table"}, 32'(table_out), 32'(f));
        chk({tag, "_err"},   32'(err_count), 32'(errs));
        chk({tag, "_pass"},  32'(pass), 32'(errs == 0));
        chk({tag, "_vecend"}, 32'(vec_out), 32'(NV - 1));
        @(negedge clk);
        chk({tag, "_done_clr"}, 32'(done), 32'd0);
        chk({tag, "_hold_tbl"}, 32'(table_out), 32'(f));
        chk({tag, "_hold_err"}, 32'(err_count), 32'(errs));
        chk({tag, "_hold_vec"}, 32'(vec_out), 32'(NV - 1));
    endtask

    initial begin
        logic [NV-1:0] rf;
        logic [NV-1:0] re;
        int            guard;
        n_cmp      = 0;
        n_bad      = 0;
        rst        = 1'b1;
        start      = 1'b0;
        exp_table  = '0;
        func       = '0;
        start1     = 1'b0;
        exp_table1 = '0;
        func1      = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_vec",   32'(vec_out),   32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_done",  32'(done),      32'd0);
        chk("rst_table", 32'(table_out), 32'd0);
        chk("rst_err",   32'(err_count), 32'd0);
        chk("rst_pass",  32'(pass),      32'd0);
        chk("rst_busy1", 32'(busy1),     32'd0);
        rst = 1'b0;

        // XOR block (true table 0x96)
        sweep(8'h96, 8'h96, 1'b0, "xor_ok");
        sweep(8'h96, 8'h69, 1'b0, "xor_inv");
        sweep(8'hC0, 8'hC1, 1'b0, "and_ab");
        sweep(8'h96, 8'h96, 1'b1, "xor_extra");

        // Randomized blocks and expectations
        for (int r = 0; r < 4; r++) begin
            rf = 8'($urandom);
            re = (r == 0) ? rf : (rf ^ 8'($urandom));
            sweep(rf, re, 1'b0, $sformatf("rand%0d", r));
        end

        // Reset mid-sweep while vec_out=4, with a failing expectation already accumulating errors
        @(negedge clk);
        func      = 8'hA5;
        exp_table = 8'h5A;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (vec_out != 3'd4 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        chk("rst_mid_reach", 32'(vec_out), 32'd4);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rstm_vec",   32'(vec_out),   32'd0);
        chk("rstm_busy",  32'(busy),      32'd0);
        chk("rstm_done",  32'(done),      32'd0);
        chk("rstm_table", 32'(table_out), 32'd0);
        chk("rstm_err",   32'(err_count), 32'd0);
        chk("rstm_pass",  32'(pass),      32'd0);
        repeat (3) @(negedge clk);
        chk("rstm_idle",  32'(busy),      32'd0);
        sweep(8'hA5, 8'hA5, 1'b0, "after_rst");

        // DWELL=1 with start held continuously
        @(negedge clk);
        func1      = 8'($urandom);
        exp_table1 = func1;
        start1     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NV; k++) begin
            chk($sformatf("d1_busy_%0d", k), 32'(busy1), 32'd1);
            chk($sformatf("d1_vec_%0d", k), 32'(vec_out1), 32'(k));
            @(negedge clk);
        end
        chk("d1_done",  32'(done1),      32'd1);
        chk("d1_table", 32'(table_out1), 32'(func1));
        chk("d1_err",   32'(err_count1), 32'd0);
        chk("d1_pass",  32'(pass1),      32'd1);
        @(negedge clk);
        chk("d1_idle_busy", 32'(busy1), 32'd0);
        chk("d1_idle_done", 32'(done1), 32'd0);
        chk("d1_idle_pass", 32'(pass1), 32'd1);
        @(negedge clk);
        chk("d1_re_busy",  32'(busy1),      32'd1);
        chk("d1_re_vec",   32'(vec_out1),   32'd0);
        chk("d1_re_table", 32'(table_out1), 32'd0);
        chk("d1_re_pass",  32'(pass1),      32'd0);
        chk("d1_re_err",   32'(err_count1), 32'd0);
        repeat (NV) @(negedge clk);
        chk("d1_done2",  32'(done1),      32'd1);
        chk("d1_table2", 32'(table_out1), 32'(func1));
        chk("d1_pass2",  32'(pass1),      32'd1);
        start1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("d1_stop", 32'(busy1), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
